// File: rtl/conv_window_ctrl.sv
// -----------------------------------------------------------------------------
// conv_window_ctrl
//
// Frame sequencer for a KxK sliding-window shift register. It accepts a
// raster-order pixel stream (valid/ready), forwards each accepted pixel into
// the shift register, tracks the row/column of the pixel being written, and
// flags the cycle after every write that completes a geometrically valid
// window. A window is never formed across a row edge. Downstream
// backpressure (m_ready) stalls the pixel stream while a window is pending.
//
// Flow: IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        one-cycle frame start pulse, only honoured in IDLE
//   s_valid      input pixel valid
//   s_data       input pixel (raster order)
//   s_ready      pixel accepted this cycle when s_valid is also high
//   sr_clear     synchronous clear to the shift register
//   sr_write_en  shift enable to the shift register
//   sr_pixel     pixel into the shift register
//   sr_ready     shift register ready (only used with the check option)
//   m_ready      downstream accepts the current window
//   win_valid    shift register currently holds a valid window
//   win_row      top-left row of the current window
//   win_col      top-left column of the current window
//   busy         high whenever the sequencer is not IDLE
//   frame_done   one-cycle pulse at the end of a frame
//   sr_err       (CONV_CTRL_SR_CHECK_EN only) sticky: the shift register
//                reported not-ready while a window was declared
//
// Build option
//   CONV_CTRL_SR_CHECK_EN  adds the sr_err output and its check logic.
// -----------------------------------------------------------------------------
module conv_window_ctrl #(
    parameter int BITS        = 9,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_LENGTH  = 16,
    parameter int IMG_HEIGHT  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          s_valid,
    input  logic [BITS-1:0]               s_data,
    output logic                          s_ready,
    output logic                          sr_clear,
    output logic                          sr_write_en,
    output logic [BITS-1:0]               sr_pixel,
    input  logic                          sr_ready,
    input  logic                          m_ready,
    output logic                          win_valid,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
    output logic [$clog2(IMG_LENGTH)-1:0] win_col,
    output logic                          busy,
    output logic                          frame_done
`ifdef CONV_CTRL_SR_CHECK_EN
    ,
    output logic                          sr_err
`endif
);

    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_LENGTH);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_LENGTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_KM1  = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_KM1  = RW'(KERNEL_SIZE - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [RW-1:0]   row_r;
    logic [CW-1:0]   col_r;
    logic            win_valid_r;
    logic [RW-1:0]   win_row_r;
    logic [CW-1:0]   win_col_r;
    logic            busy_r;
    logic            frame_done_r;

    logic            stall_s;
    logic            s_ready_s;
    logic            write_s;
    logic            last_pix_s;
    logic            qualify_s;
    logic            sr_clear_s;

    // A pending window that downstream has not taken blocks the stream, so
    // neither a pixel nor the presented window can be lost.
    assign stall_s    = win_valid_r && !m_ready;
    assign s_ready_s  = (state_r == ST_STREAM) && !stall_s;
    assign write_s    = s_valid && s_ready_s;
    assign last_pix_s = (row_r == ROW_LAST) && (col_r == COL_LAST);
    // The write that lands at (r,c) completes the window whose top-left is
    // (r-K+1, c-K+1); columns below K-1 would wrap across the row edge.
    assign qualify_s  = write_s && (row_r >= ROW_KM1) && (col_r >= COL_KM1);

    assign s_ready     = s_ready_s;
    assign sr_write_en = write_s;
    assign sr_pixel    = s_data;
    assign sr_clear    = sr_clear_s;
    assign win_valid   = win_valid_r;
    assign win_row     = win_row_r;
    assign win_col     = win_col_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;

    // Next-state decode and the one-cycle shift register clear.
    always_comb begin
        state_nxt_s = state_r;
        sr_clear_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                sr_clear_s  = 1'b1;
                state_nxt_s = ST_STREAM;
            end
            ST_STREAM: begin
                if (write_s && last_pix_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                // Leave once the final window is gone or is being taken now.
                if (!win_valid_r || m_ready) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered status outputs, aligned with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            busy_r       <= (state_nxt_s != ST_IDLE);
            frame_done_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Raster position of the next pixel to be written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_r <= {RW{1'b0}};
            col_r <= {CW{1'b0}};
        end else if (state_r == ST_CLEAR) begin
            row_r <= {RW{1'b0}};
            col_r <= {CW{1'b0}};
        end else if (write_s) begin
            if (last_pix_s) begin
                row_r <= {RW{1'b0}};
                col_r <= {CW{1'b0}};
            end else if (col_r == COL_LAST) begin
                row_r <= row_r + RW'(1);
                col_r <= {CW{1'b0}};
            end else begin
                row_r <= row_r;
                col_r <= col_r + CW'(1);
            end
        end else begin
            row_r <= row_r;
            col_r <= col_r;
        end
    end

    // Window flag and coordinates. A new window wins over consumption, which
    // gives one window per cycle when downstream takes every window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_valid_r <= 1'b0;
            win_row_r   <= {RW{1'b0}};
            win_col_r   <= {CW{1'b0}};
        end else if (qualify_s) begin
            win_valid_r <= 1'b1;
            win_row_r   <= row_r - ROW_KM1;
            win_col_r   <= col_r - COL_KM1;
        end else if (m_ready) begin
            win_valid_r <= 1'b0;
            win_row_r   <= win_row_r;
            win_col_r   <= win_col_r;
        end else begin
            win_valid_r <= win_valid_r;
            win_row_r   <= win_row_r;
            win_col_r   <= win_col_r;
        end
    end

`ifdef CONV_CTRL_SR_CHECK_EN
    logic sr_err_r;

    // Sticky error: a window was declared while the shift register was not ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_err_r <= 1'b0;
        end else if (win_valid_r && !sr_ready) begin
            sr_err_r <= 1'b1;
        end else begin
            sr_err_r <= sr_err_r;
        end
    end

    assign sr_err = sr_err_r;
`else
    logic unused_sr_ready_s;
    assign unused_sr_ready_s = sr_ready;
`endif

endmodule
